// File: rtl/edge_tick_if.sv
// Control and status bundle for edge_tick_counter: enable, clear and terminal
// count go in; the registered count and its step/wrap pulses come out.
interface edge_tick_if #(
  parameter int W = 4
);
  logic         en;
  logic         clear;
  logic [W-1:0] limit;
  logic [W-1:0] Q;
  logic         tick;
  logic         wrap;

  modport master (output en, clear, limit, input  Q, tick, wrap);
  modport slave  (input  en, clear, limit, output Q, tick, wrap);
endinterface

// File: rtl/edge_tick_counter.sv
// Prescaled modulo counter: every DIV enabled cycles Q steps 0..limit and
// wraps, with registered one-cycle tick/wrap pulses aligned to the new Q.
module edge_tick_counter #(
  parameter int DIV = 50000000,
  parameter int W   = 4
) (
  input logic        CLOCK_50,
  input logic        reset,
  edge_tick_if.slave bus
);

  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic [W-1:0]  q;
  logic          tick_r;
  logic          wrap_r;
  logic          step;

  // With DIV=1 the prescaler is pinned at 0 == PRE_LAST, so every enabled cycle steps.
  assign step = bus.en && (pre == PRE_LAST);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      q      <= '0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (bus.clear) begin
      pre    <= '0;
      q      <= '0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (bus.en) begin
      tick_r <= step;
      if (step) begin
        pre <= '0;
        // >= also catches a limit lowered below the current count mid-run.
        if (q >= bus.limit) begin
          q      <= '0;
          wrap_r <= 1'b1;
        end else begin
          q      <= q + W'(1);
          wrap_r <= 1'b0;
        end
      end else begin
        pre    <= pre + PW'(1);
        wrap_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end
  end

  assign bus.Q    = q;
  assign bus.tick = tick_r;
  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_edge_tick_counter.sv
// Bench for edge_tick_counter: a DIV=4 and a DIV=1 instance share clock, reset,
// enable and clear, and are compared every cycle against an arithmetic model.
module tb_edge_tick_counter;
  localparam int W = 4;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #5 CLOCK_50 = ~CLOCK_50;

  edge_tick_if #(.W(W)) bus4 ();
  edge_tick_if #(.W(W)) bus1 ();

  edge_tick_counter #(.DIV(4), .W(W)) dut4 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus4));
  edge_tick_counter #(.DIV(1), .W(W)) dut1 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: m_n counts enabled edges since reset/clear; a step happens
  // whenever that count reaches a multiple of DIV.
  int m_n[2];
  int m_q[2];
  int m_tick[2];
  int m_wrap[2];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_q[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end
  endfunction

  function automatic void model_edge(input bit e, input bit c, input int lim4, input int lim1);
    for (int k = 0; k < 2; k++) begin
      int div;
      int lim;
      div = (k == 0) ? 4 : 1;
      lim = (k == 0) ? lim4 : lim1;
      m_tick[k] = 0;
      m_wrap[k] = 0;
      if (c) begin
        m_n[k] = 0;
        m_q[k] = 0;
      end else if (e) begin
        m_n[k] = m_n[k] + 1;
        if (m_n[k] % div == 0) begin
          m_tick[k] = 1;
          if (m_q[k] >= lim) begin
            m_q[k]    = 0;
            m_wrap[k] = 1;
          end else begin
            m_q[k] = m_q[k] + 1;
          end
        end
      end
    end
  endfunction

  // Drive inputs, take one rising edge, then compare both instances to the model.
  task automatic step_cycle(input bit e, input bit c, input int lim4, input int lim1);
    bus4.en = e; bus4.clear = c; bus4.limit = W'(lim4);
    bus1.en = e; bus1.clear = c; bus1.limit = W'(lim1);
    @(posedge CLOCK_50);
    model_edge(e, c, lim4, lim1);
    #1;
    check("q4",    int'(bus4.Q),    m_q[0]);
    check("tick4", int'(bus4.tick), m_tick[0]);
    check("wrap4", int'(bus4.wrap), m_wrap[0]);
    check("q1",    int'(bus1.Q),    m_q[1]);
    check("tick1", int'(bus1.tick), m_tick[1]);
    check("wrap1", int'(bus1.wrap), m_wrap[1]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q4"},    int'(bus4.Q),    0);
    check({tag, "_tick4"}, int'(bus4.tick), 0);
    check({tag, "_wrap4"}, int'(bus4.wrap), 0);
    check({tag, "_q1"},    int'(bus1.Q),    0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_cnt, first_wrap, found, cycles, q_frozen, lim4, lim1;
    int exp_seq[6];
    int got_seq[$];

    // Reset is visible before any clock edge and holds through edges.
    reset = 1'b1;
    bus4.en = 1'b1; bus4.clear = 1'b0; bus4.limit = '0;
    bus1.en = 1'b1; bus1.clear = 1'b0; bus1.limit = '0;
    #1;
    check_zero("rst_async");
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_zero("rst_held");
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();

    // Full 0..15 run: tick every 4th cycle, first wrap on the 64th cycle.
    tick_cnt = 0; first_wrap = 0;
    for (int i = 1; i <= 80; i++) begin
      step_cycle(1, 0, 15, 15);
      if (bus4.tick) tick_cnt++;
      if (bus4.wrap && first_wrap == 0) first_wrap = i;
    end
    check("run_ticks", tick_cnt, 20);
    check("run_first_wrap_cycle", first_wrap, 64);

    // limit=5 sequence, then limit lowered to 2 while Q=4.
    exp_seq = '{1, 2, 3, 4, 5, 0};
    step_cycle(1, 1, 5, 0);
    for (int i = 0; i < 24; i++) begin
      step_cycle(1, 0, 5, 0);
      if (bus4.tick) begin
        got_seq.push_back(int'(bus4.Q));
        check("lim5_wrap_flag", int'(bus4.wrap), (bus4.Q == 0) ? 1 : 0);
      end
    end
    check("lim5_count", got_seq.size(), 6);
    for (int i = 0; i < 6 && i < got_seq.size(); i++) check("lim5_seq", got_seq[i], exp_seq[i]);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step_cycle(1, 0, 5, 0);
      if (bus4.Q == 4) found = 1;
    end
    check("lim5_reach_q4", found, 1);
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step_cycle(1, 0, 2, 0);
      if (bus4.tick) found = 1;
    end
    check("lim_lowered_tick", found, 1);
    check("lim_lowered_q", int'(bus4.Q), 0);
    check("lim_lowered_wrap", int'(bus4.wrap), 1);

    // DIV=1, limit=0: Q stays 0, tick and wrap every cycle.
    for (int i = 0; i < 8; i++) begin
      step_cycle(1, 0, 15, 0);
      check("div1_q", int'(bus1.Q), 0);
      check("div1_tick", int'(bus1.tick), 1);
      check("div1_wrap", int'(bus1.wrap), 1);
    end

    // Enable dropped with the prescaler at 2: frozen, then tick 2 cycles after resume.
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step_cycle(1, 0, 15, 0);
      if (m_n[0] % 4 == 2) found = 1;
    end
    check("en_reach_pre2", found, 1);
    q_frozen = m_q[0];
    for (int i = 0; i < 10; i++) begin
      step_cycle(0, 0, 15, 0);
      check("en_off_q", int'(bus4.Q), q_frozen);
      check("en_off_tick", int'(bus4.tick), 0);
      check("en_off_tick1", int'(bus1.tick), 0);
    end
    cycles = 0; found = 0;
    for (int i = 1; i <= 8 && found == 0; i++) begin
      step_cycle(1, 0, 15, 0);
      if (bus4.tick) begin found = 1; cycles = i; end
    end
    check("en_resume_latency", cycles, 2);

    // Clear on a step cycle with Q=7: no tick/wrap, next tick 4 cycles later.
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      step_cycle(1, 0, 15, 0);
      if (m_q[0] == 7 && m_n[0] % 4 == 3) found = 1;
    end
    check("clr_reach_q7", found, 1);
    step_cycle(1, 1, 15, 0);
    check_zero("clr_step");
    cycles = 0; found = 0;
    for (int i = 1; i <= 8 && found == 0; i++) begin
      step_cycle(1, 0, 15, 0);
      if (bus4.tick) begin found = 1; cycles = i; end
    end
    check("clr_next_tick", cycles, 4);

    // Asynchronous reset between edges with Q=9.
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      step_cycle(1, 0, 15, 0);
      if (m_q[0] == 9) found = 1;
    end
    check("rst_reach_q9", found, 1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(posedge CLOCK_50);
    #1;
    check_zero("rst_mid_held");
    @(negedge CLOCK_50);
    reset = 1'b0;
    cycles = 0; found = 0;
    for (int i = 1; i <= 8 && found == 0; i++) begin
      step_cycle(1, 0, 15, 0);
      if (bus4.tick) begin found = 1; cycles = i; end
    end
    check("rst_first_tick", cycles, 4);

    // Randomized enable, clear and limit changes.
    lim4 = 15; lim1 = 3;
    for (int i = 0; i < 3000; i++) begin
      bit e, c;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 24) == 0) lim4 = $urandom_range(0, 15);
      if ($urandom_range(0, 24) == 0) lim1 = $urandom_range(0, 15);
      step_cycle(e, c, lim4, lim1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
